// File: rtl/proc_run_ctrl_if.sv
// Harness-side bundle for the processor run controller: run requests and processor status in,
// sequencing controls and run statistics out.
interface proc_run_ctrl_if #(
   parameter int unsigned CNT_W = 32
);
   logic             start;
   logic             halt;
   logic             instr_retired;
   logic             proc_reset_n;
   logic             proc_clk_en;
   logic             running;
   logic             done;
   logic             timeout;
   logic [CNT_W-1:0] cycle_count;
   logic [CNT_W-1:0] retired_count;

   modport master (
      output start, halt, instr_retired,
      input  proc_reset_n, proc_clk_en, running, done, timeout, cycle_count, retired_count
   );

   modport slave (
      input  start, halt, instr_retired,
      output proc_reset_n, proc_clk_en, running, done, timeout, cycle_count, retired_count
   );
endinterface

// File: rtl/proc_run_ctrl.sv
// Run controller for the pipeline processor: sequences its reset, gates its clock, drains after
// halt, and reports completion or watchdog timeout with cycle and retired-instruction counts.
module proc_run_ctrl #(
   parameter int unsigned RST_CYCLES   = 4,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned MAX_CYCLES   = 100000,
   parameter int unsigned CNT_W        = 32
) (
   input logic               clk,
   input logic               reset,
   proc_run_ctrl_if.slave    bus
);

   localparam int unsigned RstW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam int unsigned DrnW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [RstW-1:0]  RstLast = RstW'(RST_CYCLES - 1);
   localparam logic [DrnW-1:0]  DrnLast = DrnW'((DRAIN_CYCLES == 0) ? 0 : DRAIN_CYCLES - 1);
   localparam logic [CNT_W-1:0] WdLast  = CNT_W'(MAX_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StReset, StRun, StDrain, StDone} state_e;

   state_e           state_q;
   logic [RstW-1:0]  rst_cnt_q;
   logic [DrnW-1:0]  drn_cnt_q;
   logic             proc_reset_n_q;
   logic             proc_clk_en_q;
   logic             running_q;
   logic             done_q;
   logic             timeout_q;
   logic [CNT_W-1:0] cycle_q;
   logic [CNT_W-1:0] retired_q;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= StIdle;
         rst_cnt_q      <= '0;
         drn_cnt_q      <= '0;
         proc_reset_n_q <= 1'b0;
         proc_clk_en_q  <= 1'b0;
         running_q      <= 1'b0;
         done_q         <= 1'b0;
         timeout_q      <= 1'b0;
         cycle_q        <= '0;
         retired_q      <= '0;
      end else begin
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  state_q        <= StReset;
                  rst_cnt_q      <= '0;
                  proc_reset_n_q <= 1'b0;
                  proc_clk_en_q  <= 1'b1;
                  done_q         <= 1'b0;
                  timeout_q      <= 1'b0;
                  cycle_q        <= '0;
                  retired_q      <= '0;
               end
            end
            StReset: begin
               if (rst_cnt_q == RstLast) begin
                  state_q        <= StRun;
                  proc_reset_n_q <= 1'b1;
                  running_q      <= 1'b1;
               end else begin
                  rst_cnt_q <= rst_cnt_q + 1'b1;
               end
            end
            StRun: begin
               cycle_q <= sat_inc(cycle_q);
               if (bus.instr_retired) retired_q <= sat_inc(retired_q);
               // Halt has priority over the watchdog when both hit on the same edge.
               if (bus.halt) begin
                  if (DRAIN_CYCLES == 0) begin
                     state_q       <= StDone;
                     running_q     <= 1'b0;
                     proc_clk_en_q <= 1'b0;
                     done_q        <= 1'b1;
                  end else begin
                     state_q   <= StDrain;
                     drn_cnt_q <= '0;
                  end
               end else if (cycle_q == WdLast) begin
                  state_q       <= StDone;
                  running_q     <= 1'b0;
                  proc_clk_en_q <= 1'b0;
                  done_q        <= 1'b1;
                  timeout_q     <= 1'b1;
               end
            end
            StDrain: begin
               cycle_q <= sat_inc(cycle_q);
               if (bus.instr_retired) retired_q <= sat_inc(retired_q);
               if (drn_cnt_q == DrnLast) begin
                  state_q       <= StDone;
                  running_q     <= 1'b0;
                  proc_clk_en_q <= 1'b0;
                  done_q        <= 1'b1;
               end else begin
                  drn_cnt_q <= drn_cnt_q + 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.proc_reset_n  = proc_reset_n_q;
   assign bus.proc_clk_en   = proc_clk_en_q;
   assign bus.running       = running_q;
   assign bus.done          = done_q;
   assign bus.timeout       = timeout_q;
   assign bus.cycle_count   = cycle_q;
   assign bus.retired_count = retired_q;

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Scoreboard bench for proc_run_ctrl: each run pushes its expected completion record, and a
// monitor compares it when done rises.
module tb_proc_run_ctrl;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   rst_lo;
   logic prev_done;
   int   n;

   typedef struct {
      string       name;
      logic        timeout;
      logic [15:0] cyc;
      logic [15:0] ret;
      int          rst_lo;
   } exp_t;

   exp_t sb[$];

   proc_run_ctrl_if #(.CNT_W(16)) bus ();

   proc_run_ctrl #(
      .RST_CYCLES  (4),
      .DRAIN_CYCLES(4),
      .MAX_CYCLES  (20),
      .CNT_W       (16)
   ) dut (
      .clk  (clk),
      .reset(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (!bus.done && edges < 100) begin
         step(1);
         edges++;
      end
      if (!bus.done) check("done_wait_budget", 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_proc_reset_n"}, 32'(bus.proc_reset_n), 0);
      check({tag, "_proc_clk_en"}, 32'(bus.proc_clk_en), 0);
      check({tag, "_running"}, 32'(bus.running), 0);
      check({tag, "_done"}, 32'(bus.done), 0);
      check({tag, "_timeout"}, 32'(bus.timeout), 0);
      check({tag, "_cycle_count"}, 32'(bus.cycle_count), 0);
      check({tag, "_retired_count"}, 32'(bus.retired_count), 0);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
   endtask

   // Monitor: tracks held-in-reset clocked cycles and scores each completion.
   initial begin
      rst_lo    = 0;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            rst_lo    = 0;
            prev_done = 1'b0;
         end else begin
            if (bus.proc_clk_en && !bus.proc_reset_n) rst_lo++;
            if (bus.done && !prev_done) begin
               if (sb.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  check({e.name, "_timeout"}, 32'(bus.timeout), 32'(e.timeout));
                  check({e.name, "_cycle_count"}, 32'(bus.cycle_count), 32'(e.cyc));
                  check({e.name, "_retired_count"}, 32'(bus.retired_count), 32'(e.ret));
                  check({e.name, "_proc_clk_en"}, 32'(bus.proc_clk_en), 0);
                  check({e.name, "_running"}, 32'(bus.running), 0);
                  check({e.name, "_proc_reset_n"}, 32'(bus.proc_reset_n), 1);
                  check({e.name, "_reset_cycles"}, 32'(rst_lo), 32'(e.rst_lo));
               end
               rst_lo = 0;
            end
            prev_done = bus.done;
         end
      end
   end

   initial begin
      checks            = 0;
      errors            = 0;
      rst_n             = 1'b0;
      bus.start         = 1'b0;
      bus.halt          = 1'b0;
      bus.instr_retired = 1'b0;
      #2;
      check_reset_outputs("por");
      step(2);
      rst_n = 1'b1;
      step(1);

      // Normal run: halt on the 10th RUN edge.
      sb.push_back('{name: "normal", timeout: 1'b0, cyc: 16'd14, ret: 16'd0, rst_lo: 4});
      pulse_start();
      step(4);
      check("normal_in_run", 32'({bus.running, bus.proc_reset_n}), 3);
      step(9);
      bus.halt = 1'b1;
      step(1);
      bus.halt = 1'b0;
      check("normal_cycle_at_halt", 32'(bus.cycle_count), 10);
      wait_done(n);
      check("normal_drain_edges", 32'(n), 4);

      // Restart from DONE, start held through RESET and RUN, then watchdog fires.
      sb.push_back('{name: "watchdog", timeout: 1'b1, cyc: 16'd20, ret: 16'd0, rst_lo: 4});
      bus.start = 1'b1;
      step(1);
      check("restart_done", 32'(bus.done), 0);
      check("restart_counts", 32'({bus.cycle_count, bus.retired_count}), 0);
      check("restart_in_reset", 32'({bus.proc_clk_en, bus.proc_reset_n}), 2);
      step(4);
      step(15);
      check("start_ignored_cycle", 32'(bus.cycle_count), 15);
      bus.start = 1'b0;
      wait_done(n);
      check("watchdog_edges", 32'(n), 5);

      // Halt and watchdog on the same edge: halt wins.
      sb.push_back('{name: "race", timeout: 1'b0, cyc: 16'd24, ret: 16'd0, rst_lo: 4});
      pulse_start();
      step(4);
      step(19);
      bus.halt = 1'b1;
      step(1);
      bus.halt = 1'b0;
      check("race_still_running", 32'({bus.done, bus.running}), 1);
      wait_done(n);

      // Async reset dropped between edges mid-run.
      pulse_start();
      step(4);
      step(5);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async");
      step(1);
      rst_n = 1'b1;

      // Retire counting: 3 in IDLE (ignored), 7 in RUN, 2 in DRAIN.
      sb.push_back('{name: "retire", timeout: 1'b0, cyc: 16'd14, ret: 16'd9, rst_lo: 4});
      bus.instr_retired = 1'b1;
      step(3);
      bus.instr_retired = 1'b0;
      check("idle_retire_ignored", 32'(bus.retired_count), 0);
      pulse_start();
      step(4);
      bus.instr_retired = 1'b1;
      step(7);
      bus.instr_retired = 1'b0;
      step(2);
      bus.halt = 1'b1;
      step(1);
      bus.halt = 1'b0;
      bus.instr_retired = 1'b1;
      step(2);
      bus.instr_retired = 1'b0;
      wait_done(n);

      step(3);
      check("scoreboard_drained", 32'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
